// File: rtl/fetch_pc_pkg.sv
// Shared types for the IF-stage PC generator: pipeline control, fetch FSM
// states and the redirect record passed between arbitration and PC logic.
package fetch_pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;

  typedef enum logic {FETCH_RUN, FETCH_HALT} FetchState;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } FetchRedirect;

endpackage

// File: rtl/redirect_arb.sv
// Redirect arbitration: picks between trap, branch and a latched pending
// redirect. Branches are ignored while the fetch FSM is halted.
module redirect_arb
  import fetch_pc_pkg::*;
#(
  parameter bit TRAP_PRIO = 1'b1
) (
  input  logic         halted,
  input  logic         trap_valid,
  input  logic [31:0]  trap_target,
  input  logic         br_valid,
  input  logic [31:0]  br_target,
  input  FetchRedirect pend,
  output FetchRedirect req,
  output FetchRedirect sel
);

  logic br_ok;

  // req is a fresh redirect this cycle; sel falls back to the pending one
  always_comb begin
    br_ok = br_valid && !halted;
    req   = '0;
    if (trap_valid && (TRAP_PRIO || !br_ok)) begin
      req.valid  = 1'b1;
      req.target = trap_target;
    end else if (br_ok) begin
      req.valid  = 1'b1;
      req.target = br_target;
    end
    sel = req.valid ? req : pend;
  end

endmodule

// File: rtl/fetch_pc.sv
// IF-stage program counter: produces the icache fetch address, tracks the
// PC/fault of the slot the icache registered and hands it to decode.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter bit          TRAP_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  PipeControl  pipe,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  input  logic        icache_error,
  output logic [31:0] addr,
  output logic [31:0] addr_ff,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic        fault_id
);

  FetchState    state, state_next;
  FetchRedirect req, sel, pend;
  logic         err_ff;
  logic         first_ff;
  logic         halted;
  logic         redirect_seen;
  logic         slot_live;

  assign halted = (state == FETCH_HALT);

  redirect_arb #(
    .TRAP_PRIO (TRAP_PRIO)
  ) u_arb (
    .halted      (halted),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .pend        (pend),
    .req         (req),
    .sel         (sel)
  );

  // A stall freezes the address even when a redirect arrives; that redirect
  // is parked in pend instead. first_ff makes the first fetch hit RESET_PC.
  always_comb begin
    addr = addr_ff + 32'd4;
    if ((halted && !trap_valid) || pipe.stall)
      addr = addr_ff;
    else if (sel.valid)
      addr = sel.target;
    else if (first_ff)
      addr = addr_ff;
  end

  assign redirect_seen = sel.valid || first_ff;
  assign slot_live     = !redirect_seen && !halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_ff  <= RESET_PC;
      err_ff   <= 1'b0;
      first_ff <= 1'b1;
      pend     <= '0;
    end else if (!pipe.stall) begin
      addr_ff    <= addr;
      err_ff     <= icache_error;
      first_ff   <= 1'b0;
      pend.valid <= 1'b0;
    end else if (req.valid) begin
      pend <= req;
    end
  end

  // Flush kills the outgoing slot but leaves pc_id for debug visibility
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_id    <= '0;
      valid_id <= 1'b0;
      fault_id <= 1'b0;
    end else if (pipe.flush) begin
      valid_id <= 1'b0;
      fault_id <= 1'b0;
    end else if (!pipe.stall) begin
      pc_id    <= addr_ff;
      fault_id <= err_ff;
      valid_id <= slot_live;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_RUN:
        if (!pipe.stall && !pipe.flush && err_ff && slot_live)
          state_next = FETCH_HALT;
      FETCH_HALT:
        if (trap_valid)
          state_next = FETCH_RUN;
      default:
        state_next = FETCH_RUN;
    endcase
  end

endmodule
